// File: rtl/ico_echo_fifo.sv
// ico_echo_fifo: SPI control-endpoint test block. A header starts a transaction
// answered by two ID bytes and a status byte; the first input byte after a header
// is a command selecting a data transform (and optional flush), later input bytes
// are transformed and queued in a DEPTH-entry byte FIFO, and later output strobes
// pop the FIFO.
module ico_echo_fifo #(
   parameter int         NUM_PMODS  = 0,
   parameter int         CLK_KHZ    = 12000,
   parameter int         DEPTH      = 16,
   parameter logic [7:0] ID_BYTE0   = 8'h8F,
   parameter logic [7:0] ID_BYTE1   = 8'h2A,
   parameter logic [7:0] EMPTY_BYTE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_ctrl_si,
   input  logic       spi_ctrl_so,
   input  logic       spi_ctrl_hd,
   input  logic [7:0] spi_ctrl_di,
   output logic [7:0] spi_ctrl_do,
   input  logic       epsel
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // NUM_PMODS and CLK_KHZ exist only so generated instantiations keep elaborating.
   if (NUM_PMODS < 0 || CLK_KHZ < 0) begin : g_compat_params
   end

   typedef enum logic [1:0] {IDLE, HDR, ID1, DATA} state_t;
   typedef enum logic [1:0] {M_ECHO, M_INVERT, M_INC, M_BITREV} mode_t;

   state_t          r_state, w_state_n;
   mode_t           r_mode, w_mode_n;
   logic [7:0]      r_out, w_out_n;
   logic            r_cmd_pending, w_cmd_n;
   logic            r_ovf, w_ovf_n;
   logic            r_unf, w_unf_n;
   logic [AW-1:0]   r_rd_ptr, w_rd_ptr_n;
   logic [AW-1:0]   r_wr_ptr, w_wr_ptr_n;
   logic [CW-1:0]   r_count, w_count_n;
   logic [7:0]      r_mem [DEPTH];

   logic            w_pop;
   logic            w_push_req;
   logic            w_push;
   logic            w_flush;
   logic            w_full;
   logic [7:0]      w_xdata;

   function automatic logic [7:0] f_xform(input mode_t m, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      case (m)
         M_ECHO:   r = d;
         M_INVERT: r = ~d;
         M_INC:    r = d + 8'd1;
         M_BITREV: for (int unsigned k = 0; k < 8; k++) r[k] = d[7-k];
         default:  r = d;
      endcase
      return r;
   endfunction

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_xdata     = f_xform(r_mode, spi_ctrl_di);
   assign spi_ctrl_do = epsel ? r_out : 8'h00;

   // Next-state, output byte and FIFO bookkeeping for one strobe cycle.
   // The pop is decided from pre-cycle state first; the push then sees a slot
   // freed by that pop, and a flush from a command byte overrides both.
   always_comb begin
      w_state_n  = r_state;
      w_mode_n   = r_mode;
      w_out_n    = r_out;
      w_cmd_n    = r_cmd_pending;
      w_ovf_n    = r_ovf;
      w_unf_n    = r_unf;
      w_pop      = 1'b0;
      w_push_req = 1'b0;
      w_flush    = 1'b0;
      w_push     = 1'b0;

      if (spi_ctrl_hd) begin
         w_state_n = HDR;
         w_out_n   = ID_BYTE0;
         w_cmd_n   = 1'b1;
      end else begin
         if (spi_ctrl_so) begin
            case (r_state)
               IDLE: w_out_n = EMPTY_BYTE;
               HDR: begin
                  w_out_n   = ID_BYTE1;
                  w_state_n = ID1;
               end
               ID1: begin
                  w_out_n   = {r_ovf, r_unf, 6'(r_count)};
                  w_ovf_n   = 1'b0;
                  w_unf_n   = 1'b0;
                  w_state_n = DATA;
               end
               DATA: begin
                  if (r_count != '0) begin
                     w_out_n = r_mem[r_rd_ptr];
                     w_pop   = 1'b1;
                  end else begin
                     w_out_n = EMPTY_BYTE;
                     w_unf_n = 1'b1;
                  end
               end
               default: w_state_n = IDLE;
            endcase
         end
         if (spi_ctrl_si) begin
            if (r_cmd_pending) begin
               w_mode_n = mode_t'(spi_ctrl_di[1:0]);
               w_flush  = spi_ctrl_di[7];
               w_cmd_n  = 1'b0;
            end else begin
               w_push_req = 1'b1;
            end
         end
      end

      w_push = w_push_req & (~w_full | w_pop);
      if (w_push_req & w_full & ~w_pop) w_ovf_n = 1'b1;

      w_rd_ptr_n = r_rd_ptr + (w_pop ? AW'(1) : AW'(0));
      w_wr_ptr_n = r_wr_ptr + (w_push ? AW'(1) : AW'(0));
      w_count_n  = r_count + CW'(w_push) - CW'(w_pop);
      if (w_flush) begin
         w_rd_ptr_n = '0;
         w_wr_ptr_n = '0;
         w_count_n  = '0;
      end
   end

   // Control and status registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_mode        <= M_ECHO;
         r_out         <= 8'h00;
         r_cmd_pending <= 1'b0;
         r_ovf         <= 1'b0;
         r_unf         <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_state       <= w_state_n;
         r_mode        <= w_mode_n;
         r_out         <= w_out_n;
         r_cmd_pending <= w_cmd_n;
         r_ovf         <= w_ovf_n;
         r_unf         <= w_unf_n;
         r_rd_ptr      <= w_rd_ptr_n;
         r_wr_ptr      <= w_wr_ptr_n;
         r_count       <= w_count_n;
      end
   end

   // FIFO storage; contents are meaningless once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_xdata;
   end

endmodule

// File: tb/tb_ico_echo_fifo.sv
// Bench for ico_echo_fifo: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_ico_echo_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       si = 1'b0, so = 1'b0, hd = 1'b0, epsel = 1'b1;
   logic [7:0] di = 8'h00;
   logic [7:0] dout;

   int n_checks = 0;
   int n_errors = 0;

   ico_echo_fifo #(
      .NUM_PMODS (0),
      .CLK_KHZ   (12000),
      .DEPTH     (DEPTH),
      .ID_BYTE0  (8'h8F),
      .ID_BYTE1  (8'h2A),
      .EMPTY_BYTE(8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_ctrl_si(si),
      .spi_ctrl_so(so),
      .spi_ctrl_hd(hd),
      .spi_ctrl_di(di),
      .spi_ctrl_do(dout),
      .epsel      (epsel)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit h, input bit i, input bit o, input logic [7:0] d);
      @(negedge clk);
      hd = h; si = i; so = o; di = d;
      @(posedge clk);
      #1;
      hd = 1'b0; si = 1'b0; so = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- reference model ----------------
   localparam int S_IDLE = 0, S_HDR = 1, S_ID1 = 2, S_DATA = 3;
   logic [7:0] m_q[$];
   int         m_state;
   int         m_mode;
   bit         m_cmd, m_ovf, m_unf;
   logic [7:0] m_out;

   function automatic logic [7:0] ref_xform(input int m, input logic [7:0] d);
      logic [7:0] r;
      case (m)
         0: r = d;
         1: r = ~d;
         2: r = d + 8'd1;
         default: for (int k = 0; k < 8; k++) r[k] = d[7-k];
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_state = S_IDLE; m_mode = 0; m_cmd = 0; m_ovf = 0; m_unf = 0; m_out = 8'h00;
   endtask

   // Applies the transaction rules in order: header wins, else output strobe
   // against current contents, then input strobe.
   task automatic model_step(input bit h, input bit i, input bit o, input logic [7:0] d);
      if (h) begin
         m_state = S_HDR; m_out = 8'h8F; m_cmd = 1;
         return;
      end
      if (o) begin
         case (m_state)
            S_IDLE: m_out = 8'h00;
            S_HDR: begin m_out = 8'h2A; m_state = S_ID1; end
            S_ID1: begin
               m_out = {m_ovf, m_unf, 6'(m_q.size())};
               m_ovf = 0; m_unf = 0; m_state = S_DATA;
            end
            default: begin
               if (m_q.size() > 0) m_out = m_q.pop_front();
               else begin m_out = 8'h00; m_unf = 1; end
            end
         endcase
      end
      if (i) begin
         if (m_cmd) begin
            m_mode = int'(d[1:0]);
            if (d[7]) m_q.delete();
            m_cmd = 0;
         end else if (m_q.size() < DEPTH) begin
            m_q.push_back(ref_xform(m_mode, d));
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         hd;
      bit         si;
      bit         so;
      logic [7:0] di;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[34];

   initial begin
      // empty-FIFO transaction and unf reporting
      tbl[0]  = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[1]  = '{0, 0, 1, 8'h00, 8'h2A};
      tbl[2]  = '{0, 0, 1, 8'h00, 8'h00};
      tbl[3]  = '{0, 0, 1, 8'h00, 8'h00};
      tbl[4]  = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[5]  = '{0, 0, 1, 8'h00, 8'h2A};
      tbl[6]  = '{0, 0, 1, 8'h00, 8'h40};
      // echo three bytes
      tbl[7]  = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[8]  = '{0, 1, 0, 8'h00, 8'h8F};
      tbl[9]  = '{0, 1, 0, 8'h11, 8'h8F};
      tbl[10] = '{0, 1, 0, 8'h22, 8'h8F};
      tbl[11] = '{0, 1, 0, 8'h33, 8'h8F};
      tbl[12] = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[13] = '{0, 0, 1, 8'h00, 8'h2A};
      tbl[14] = '{0, 0, 1, 8'h00, 8'h03};
      tbl[15] = '{0, 0, 1, 8'h00, 8'h11};
      tbl[16] = '{0, 0, 1, 8'h00, 8'h22};
      tbl[17] = '{0, 0, 1, 8'h00, 8'h33};
      // transforms: invert, increment with wrap, bit reverse
      tbl[18] = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[19] = '{0, 1, 0, 8'h01, 8'h8F};
      tbl[20] = '{0, 1, 0, 8'h0F, 8'h8F};
      tbl[21] = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[22] = '{0, 1, 0, 8'h02, 8'h8F};
      tbl[23] = '{0, 1, 0, 8'hFF, 8'h8F};
      tbl[24] = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[25] = '{0, 1, 0, 8'h03, 8'h8F};
      tbl[26] = '{0, 1, 0, 8'h01, 8'h8F};
      tbl[27] = '{1, 0, 0, 8'h00, 8'h8F};
      tbl[28] = '{0, 0, 1, 8'h00, 8'h2A};
      tbl[29] = '{0, 0, 1, 8'h00, 8'h03};
      tbl[30] = '{0, 0, 1, 8'h00, 8'hF0};
      tbl[31] = '{0, 0, 1, 8'h00, 8'h00};
      tbl[32] = '{0, 0, 1, 8'h00, 8'h80};
      tbl[33] = '{0, 0, 1, 8'h00, 8'h00};

      // reset state, including output forced low while reset is held
      #1;
      check("do_during_reset", dout, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("do_after_reset", dout, 8'h00);

      for (int v = 0; v < 34; v++) begin
         drive(tbl[v].hd, tbl[v].si, tbl[v].so, tbl[v].di);
         check($sformatf("vec%0d", v), dout, tbl[v].exp);
      end

      // ---- overflow at DEPTH and simultaneous push/pop while full ----
      pulse_reset();
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h00);
      for (int k = 0; k <= DEPTH; k++) drive(0, 1, 0, 8'hA0 + 8'(k));
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h00);
      drive(0, 0, 1, 8'h00);
      check("ovf_id1", dout, 8'h2A);
      drive(0, 0, 1, 8'h00);
      check("ovf_status", dout, 8'h90);
      drive(0, 1, 1, 8'h55);
      check("full_sisos_pop", dout, 8'hA0);
      for (int k = 1; k < DEPTH; k++) begin
         drive(0, 0, 1, 8'h00);
         check($sformatf("full_read%0d", k), dout, 8'hA0 + 8'(k));
      end
      drive(0, 0, 1, 8'h00);
      check("full_read_pushed", dout, 8'h55);
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, 8'h00);
      check("full_sisos_no_ovf", dout, 8'h00);

      // ---- flush command with the endpoint deselected ----
      epsel = 1'b0;
      drive(1, 0, 0, 8'h00);
      check("desel_hdr", dout, 8'h00);
      drive(0, 1, 0, 8'h00);
      for (int k = 1; k <= 5; k++) drive(0, 1, 0, 8'(k));
      check("desel_push", dout, 8'h00);
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h80);
      drive(0, 0, 1, 8'h00);
      check("desel_id1", dout, 8'h00);
      epsel = 1'b1;
      #1;
      check("sel_id1", dout, 8'h2A);
      epsel = 1'b0;
      drive(0, 0, 1, 8'h00);
      check("desel_status", dout, 8'h00);
      epsel = 1'b1;
      #1;
      check("flush_status", dout, 8'h00);

      // ---- asynchronous reset mid-transaction ----
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h00);
      for (int k = 0; k < 3; k++) drive(0, 1, 0, 8'hC0 + 8'(k));
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, 8'h00);
      check("pre_reset_status", dout, 8'h03);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_reset_do", dout, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h00);
      check("post_reset_id1", dout, 8'h2A);
      drive(0, 0, 1, 8'h00);
      check("post_reset_status", dout, 8'h00);

      // ---- randomized run against the reference model ----
      pulse_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         bit         rh, ri, ro;
         logic [7:0] rd;
         rh    = ($urandom_range(0, 99) < 4);
         ri    = ($urandom_range(0, 99) < 55);
         ro    = ($urandom_range(0, 99) < 45);
         rd    = 8'($urandom);
         epsel = ($urandom_range(0, 9) != 0);
         model_step(rh, ri, ro, rd);
         drive(rh, ri, ro, rd);
         check($sformatf("rand%0d", n), dout, epsel ? m_out : 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
